uart_tx: RTL and testbench

//  Serialises one parallel byte per request into an asynchronous UART frame:

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: state encoding,
// oversampling ratio and the parity helper used on the transmit side.
package uart_pkg;

  // Number of s_tick pulses that make up one bit period on the line.
  localparam int OVERSAMPLE = 16;

  // Frame sequencing states, common to both directions of the link.
  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_start  = 3'd1,
    st_data   = 3'd2,
    st_parity = 3'd3,
    st_stop   = 3'd4
  } uart_state_t;

  // Parity over the low dbit bits of data; odd=0 gives even parity, so the
  // returned bit makes the total count of ones (data plus parity) even.
  function automatic logic par_calc(input logic [7:0] data, input int dbit,
                                    input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < dbit) begin
        p = p ^ data[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per accepted request into a frame of
// start bit, DBIT data bits LSB first, optional parity bit and a stop period,
// timed by the 16x oversampling s_tick shared with the receiver.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  uart_state_t state, state_next;
  logic [4:0]  s_reg, s_next;
  logic [2:0]  n_reg, n_next;
  logic [7:0]  shift_reg, shift_next;
  logic        par_reg, par_next;
  logic        tx_reg, tx_next;
  logic        done;

  // Frame state, tick/bit counters, data shifter, parity bit and line flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= st_idle;
      s_reg     <= '0;
      n_reg     <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

  // Sequencing: counters move only on s_tick; the line level is derived from
  // the upcoming state so tx comes straight from a flop with no decode glitch.
  always_comb begin
    state_next = state;
    s_next     = s_reg;
    n_next     = n_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    done       = 1'b0;
    case (state)
      st_idle: begin
        if (tx_start) begin
          shift_next = din;
          par_next   = par_calc(din, DBIT, 1'(PARITY_ODD));
          s_next     = '0;
          state_next = st_start;
        end
      end
      st_start: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = st_data;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      st_data: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next     = '0;
            shift_next = {1'b0, shift_reg[7:1]};
            if (n_reg == N_LAST) begin
              state_next = (PARITY_EN != 0) ? st_parity : st_stop;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      st_parity: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next     = '0;
            state_next = st_stop;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      st_stop: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            done       = 1'b1;
            s_next     = '0;
            state_next = st_idle;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: begin
        state_next = st_idle;
      end
    endcase

    case (state_next)
      st_start:  tx_next = 1'b0;
      st_data:   tx_next = shift_next[0];
      st_parity: tx_next = par_next;
      default:   tx_next = 1'b1;
    endcase
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state != st_idle);
  assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: three differently configured
// transmitters are driven, and a per-instance monitor decodes each frame on
// the line and compares it with a frame built from the byte that was queued.
module tb_uart_tx;

  localparam int NDUT = 3;
  localparam int DB [NDUT] = '{8, 8, 7};
  localparam int SB [NDUT] = '{16, 32, 24};
  localparam int PE [NDUT] = '{0, 1, 1};
  localparam int PO [NDUT] = '{0, 0, 1};

  typedef struct {
    logic [7:0] data;
    bit         abort;
  } exp_t;

  logic            clk;
  logic            reset_n;
  logic            s_tick;
  logic [NDUT-1:0] tx_start;
  logic [7:0]      din;
  logic [NDUT-1:0] busy_w;
  logic [NDUT-1:0] done_w;
  logic [NDUT-1:0] tx_w;

  bit   pause;
  bit   rand_ticks;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx #(
      .DBIT      (DB[g]),
      .SB_TICK   (SB[g]),
      .PARITY_EN (PE[g]),
      .PARITY_ODD(PO[g])
    ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .s_tick      (s_tick),
      .tx_start    (tx_start[g]),
      .din         (din),
      .tx_busy     (busy_w[g]),
      .tx_done_tick(done_w[g]),
      .tx          (tx_w[g])
    );
  end

  // 100 MHz style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick source: fixed one-in-four, or random spacing, and can be paused.
  initial begin
    int ctr;
    int gap;
    ctr    = 0;
    gap    = 4;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pause) begin
        s_tick = 1'b0;
      end else begin
        ctr++;
        if (ctr >= gap) begin
          s_tick = 1'b1;
          ctr    = 0;
          gap    = rand_ticks ? int'($urandom_range(1, 6)) : 4;
        end else begin
          s_tick = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t qpop(input int idx);
    case (idx)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Reference frame: start 0, data LSB first, optional parity, stop 1.
  function automatic void build_frame(input logic [7:0] d, input int idx,
                                      output logic [12:0] bits, output int nb);
    int ones;
    bits = '0;
    ones = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < DB[idx]; i++) begin
      bits[1+i] = d[i];
      ones += int'(d[i]);
    end
    nb = 1 + DB[idx];
    if (PE[idx] != 0) begin
      bits[nb] = 1'((ones % 2) ^ PO[idx]);
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
  endfunction

  // Decodes frames of one instance tick by tick and scores them.
  task automatic monitor(input int idx);
    exp_t        e;
    logic [12:0] bits;
    int          nb, k, cnt, need, mism, done_err, guard;
    bit          aborted, exp_done;
    forever begin
      @(negedge clk);
      if (reset_n && tx_w[idx] === 1'b0) begin
        if (qsize(idx) == 0) begin
          checkOutput($sformatf("u%0d unexpected_frame_queue", idx), 0, 1);
          guard = 0;
          while (busy_w[idx] !== 1'b0 && guard < 20000) begin
            @(negedge clk);
            guard++;
          end
        end else begin
          e = qpop(idx);
          build_frame(e.data, idx, bits, nb);
          aborted  = 0;
          k        = 0;
          cnt      = 0;
          mism     = 0;
          done_err = 0;
          while (k < nb && !aborted) begin
            if (!reset_n) begin
              aborted = 1;
            end else begin
              if (tx_w[idx] !== bits[k] || busy_w[idx] !== 1'b1) mism++;
              need = (k == nb - 1) ? SB[idx] : 16;
              if (s_tick) cnt++;
              exp_done = s_tick && (k == nb - 1) && (cnt == need);
              if (done_w[idx] !== exp_done) done_err++;
              if (s_tick && cnt == need) begin
                checkOutput($sformatf("u%0d data %02h bit%0d(=%0d) mismatched cycles",
                                      idx, e.data, k, bits[k]), mism, 0);
                k++;
                cnt  = 0;
                mism = 0;
              end
              if (k < nb) @(negedge clk);
            end
          end
          if (aborted) begin
            checkOutput($sformatf("u%0d frame %02h aborted", idx, e.data),
                        32'(e.abort), 1);
          end else begin
            checkOutput($sformatf("u%0d frame %02h completed", idx, e.data),
                        32'(e.abort), 0);
            checkOutput($sformatf("u%0d frame %02h done_tick errors", idx, e.data),
                        done_err, 0);
            @(negedge clk);
            checkOutput($sformatf("u%0d idle after done {busy,tx}", idx),
                        {30'd0, busy_w[idx], tx_w[idx]}, 32'd1);
          end
        end
      end
    end
  endtask

  // Waits for the instance to be idle, then requests one byte.
  task automatic applyStimulus(input int idx, input logic [7:0] data,
                               input bit abort);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy_w[idx] !== 1'b0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) checkOutput($sformatf("u%0d accept_wait busy", idx),
                                   32'(busy_w[idx]), 0);
    e.data  = data;
    e.abort = abort;
    qpush(idx, e);
    din           = data;
    tx_start[idx] = 1'b1;
    @(posedge clk);
    #1;
    tx_start[idx] = 1'b0;
    din           = 8'($urandom);
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int guard;
    seen  = 0;
    guard = 0;
    while (seen < n && guard < 10000) begin
      @(negedge clk);
      if (s_tick) seen++;
      guard++;
    end
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((q0.size() + q1.size() + q2.size() != 0 || busy_w !== '0)
           && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) checkOutput("drain busy", {29'd0, busy_w}, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int clk_cnt;
    int guard;
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    tx_start   = '0;
    din        = 8'h00;
    pause      = 0;
    rand_ticks = 0;

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset tx", {29'd0, tx_w}, 32'h7);
    checkOutput("reset busy", {29'd0, busy_w}, 0);
    checkOutput("reset done", {29'd0, done_w}, 0);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] 0x55 frame timing on 8N1 instance");
    applyStimulus(0, 8'h55, 0);
    checkOutput("0x55 tx low after accept", 32'(tx_w[0]), 0);
    clk_cnt = 0;
    @(negedge clk);
    while (done_w[0] !== 1'b1 && clk_cnt < 2000) begin
      @(negedge clk);
      clk_cnt++;
    end
    checkOutput($sformatf("0x55 done offset %0d within 636..639", clk_cnt),
                32'(clk_cnt >= 636 && clk_cnt <= 639), 1);
    waitDrain();

    $display("[TB] directed and random bytes, fixed tick spacing");
    foreach (q0[i]) ;
    begin
      logic [7:0] fixed_bytes [4];
      fixed_bytes = '{8'hA3, 8'h00, 8'hFF, 8'h07};
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < NDUT; i++) applyStimulus(i, fixed_bytes[r], 0);
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NDUT; i++) applyStimulus(i, 8'($urandom), 0);
    end
    waitDrain();

    $display("[TB] requests during a frame and on the done tick");
    applyStimulus(0, 8'h12, 0);
    wait_ticks(40);
    @(negedge clk);
    din         = 8'hFF;
    tx_start[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_start[0] = 1'b0;
    guard = 0;
    @(negedge clk);
    while (done_w[0] !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("done tick seen for 0x12", 32'(done_w[0]), 1);
    din         = 8'hFF;
    tx_start[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_start[0] = 1'b0;
    waitDrain();

    $display("[TB] tick pause in the start bit");
    for (int i = 0; i < NDUT; i++) applyStimulus(i, 8'($urandom), 0);
    wait_ticks(5);
    pause = 1;
    repeat (200) @(negedge clk);
    checkOutput("tx held during pause", {29'd0, tx_w}, 0);
    pause = 0;
    waitDrain();

    $display("[TB] random bytes, random tick spacing");
    rand_ticks = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NDUT; i++) applyStimulus(i, 8'($urandom), 0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    waitDrain();
    rand_ticks = 0;

    $display("[TB] reset during data bit 3");
    for (int i = 0; i < NDUT; i++) applyStimulus(i, 8'($urandom), 1);
    wait_ticks(72);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("abort tx", {29'd0, tx_w}, 32'h7);
    checkOutput("abort busy", {29'd0, busy_w}, 0);
    checkOutput("abort done", {29'd0, done_w}, 0);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < NDUT; i++) applyStimulus(i, 8'($urandom), 0);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
